// File: rtl/eth_tx_arb_pkg.sv
// Shared types and the circular round-robin pick for the Ethernet TX arbiter.
package eth_tx_arb_pkg;

  localparam int unsigned MAX_SRC = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  typedef logic [7:0] byte_t;

  // One-hot grant for the first request at or after ptr, wrapping modulo n (n <= MAX_SRC).
  function automatic logic [MAX_SRC-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int unsigned        n);
    logic [MAX_SRC-1:0] gnt;
    logic               found;
    logic [3:0]         pos;
    gnt   = {MAX_SRC{1'b0}};
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_SRC; i++) begin
      pos = {1'b0, ptr} + 4'(i);
      if (pos >= 4'(n)) begin
        pos = pos - 4'(n);
      end
      if ((i < n) && !found && req[pos[2:0]]) begin
        gnt[pos[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Source-side and MAC-side byte stream of the TX arbiter; slave is the arbiter's view.
interface eth_tx_arbiter_if
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC-1:0]   src_valid;
  logic [NUM_SRC*8-1:0] src_data;
  logic [NUM_SRC-1:0]   src_ack;
  logic                 mac_tx_valid;
  byte_t                mac_tx_data;
  logic                 mac_tx_ack;

  modport slave (
    input  src_valid, src_data, mac_tx_ack,
    output src_ack, mac_tx_valid, mac_tx_data
  );

  modport master (
    output src_valid, src_data, mac_tx_ack,
    input  src_ack, mac_tx_valid, mac_tx_data
  );
endinterface

// File: rtl/eth_tx_rr_sel.sv
// Combinational circular priority selector: first request at or after ptr_i wins.
module eth_tx_rr_sel
  import eth_tx_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int IW = $clog2(N);

  logic [MAX_SRC-1:0] gnt_full_s;

  // Pick one-hot winner and encode its index
  always_comb begin
    gnt_full_s = rr_pick(MAX_SRC'(req_i), 3'(ptr_i), N);
    gnt_o      = gnt_full_s[N-1:0];
    any_o      = |gnt_full_s;
    idx_o      = {IW{1'b0}};
    for (int k = 0; k < MAX_SRC; k++) begin
      idx_o = idx_o | (gnt_full_s[k] ? IW'(k) : {IW{1'b0}});
    end
  end
endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-locked round-robin TX arbiter with inter-frame gap and stall watchdog.
// Define ETH_TX_ARB_STATS_EN to add per-source frame/abort counters.
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int GAP_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_tx_i,
  input  logic               rst_n,
  eth_tx_arbiter_if.slave    bus_if,
  output logic [NUM_SRC-1:0] grant_o,
  output logic               busy_o,
  output logic               timeout_o
`ifdef ETH_TX_ARB_STATS_EN
  ,
  output logic [NUM_SRC*16-1:0] frame_cnt_o,
  output logic [NUM_SRC*8-1:0]  abort_cnt_o
`endif
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_SRC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam arb_state_e    END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d, mask_q, mask_d, eligible_s, sel_gnt_s;
  logic [IW-1:0]      gidx_q, gidx_d, rr_q, rr_d, sel_idx_s, next_ptr_s;
  logic [GW-1:0]      gap_q, gap_d;
  logic [WW-1:0]      wd_q, wd_d;
  logic               timeout_q, timeout_d;
  logic               sel_any_s, cur_valid_s, frame_end_s, abort_s;
  byte_t              cur_data_s;

  // A masked (aborted) source stays out of arbitration until its valid drops
  assign eligible_s = bus_if.src_valid & ~mask_q;
  assign next_ptr_s = (gidx_q == LAST_IDX) ? {IW{1'b0}} : gidx_q + IW'(1);

  eth_tx_rr_sel #(.N(NUM_SRC)) u_rr_sel (
    .req_i (eligible_s),
    .ptr_i (rr_q),
    .gnt_o (sel_gnt_s),
    .idx_o (sel_idx_s),
    .any_o (sel_any_s)
  );

  // Mux the granted source's valid and byte
  always_comb begin
    cur_valid_s = 1'b0;
    cur_data_s  = 8'h00;
    for (int k = 0; k < NUM_SRC; k++) begin
      cur_valid_s = cur_valid_s | ((gidx_q == IW'(k)) & bus_if.src_valid[k]);
      cur_data_s  = cur_data_s | ((gidx_q == IW'(k)) ? bus_if.src_data[8*k +: 8] : 8'h00);
    end
  end

  // Next-state logic: arbitration, frame end, watchdog abort, gap count
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    rr_d        = rr_q;
    gap_d       = gap_q;
    wd_d        = wd_q;
    mask_d      = mask_q & bus_if.src_valid;
    timeout_d   = 1'b0;
    frame_end_s = 1'b0;
    abort_s     = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d  = {WW{1'b0}};
        gap_d = {GW{1'b0}};
        if (sel_any_s) begin
          gnt_d   = sel_gnt_s;
          gidx_d  = sel_idx_s;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A dropped valid wins over a simultaneous watchdog expiry
        if (!cur_valid_s) begin
          frame_end_s = 1'b1;
          rr_d        = next_ptr_s;
          wd_d        = {WW{1'b0}};
          state_d     = END_STATE;
        end else if (bus_if.mac_tx_ack) begin
          wd_d = {WW{1'b0}};
        end else if (wd_q == WD_LAST) begin
          abort_s   = 1'b1;
          timeout_d = 1'b1;
          mask_d    = mask_d | gnt_q;
          rr_d      = next_ptr_s;
          wd_d      = {WW{1'b0}};
          state_d   = END_STATE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = {GW{1'b0}};
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = {GW{1'b0}};
        wd_d    = {WW{1'b0}};
      end
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk_tx_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= {NUM_SRC{1'b0}};
      gidx_q    <= {IW{1'b0}};
      rr_q      <= {IW{1'b0}};
      gap_q     <= {GW{1'b0}};
      wd_q      <= {WW{1'b0}};
      mask_q    <= {NUM_SRC{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      rr_q      <= rr_d;
      gap_q     <= gap_d;
      wd_q      <= wd_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
    end
  end

  // Pass-through from the owner while BUSY; everything quiet otherwise
  always_comb begin
    if (state_q == BUSY) begin
      bus_if.mac_tx_valid = cur_valid_s;
      bus_if.mac_tx_data  = cur_data_s;
      bus_if.src_ack      = (cur_valid_s & bus_if.mac_tx_ack) ? gnt_q : {NUM_SRC{1'b0}};
      grant_o             = gnt_q;
    end else begin
      bus_if.mac_tx_valid = 1'b0;
      bus_if.mac_tx_data  = 8'h00;
      bus_if.src_ack      = {NUM_SRC{1'b0}};
      grant_o             = {NUM_SRC{1'b0}};
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign timeout_o = timeout_q;

`ifdef ETH_TX_ARB_STATS_EN
  logic [15:0] frame_cnt_q [NUM_SRC];
  logic [7:0]  abort_cnt_q [NUM_SRC];

  // Frame counters wrap, abort counters saturate
  always_ff @(posedge clk_tx_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        frame_cnt_q[k] <= 16'd0;
        abort_cnt_q[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (frame_end_s && (gidx_q == IW'(k))) begin
          frame_cnt_q[k] <= frame_cnt_q[k] + 16'd1;
        end
        if (abort_s && (gidx_q == IW'(k)) && (abort_cnt_q[k] != 8'hFF)) begin
          abort_cnt_q[k] <= abort_cnt_q[k] + 8'd1;
        end
      end
    end
  end

  // Flatten counter arrays onto the output buses
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      frame_cnt_o[16*k +: 16] = frame_cnt_q[k];
      abort_cnt_o[8*k +: 8]   = abort_cnt_q[k];
    end
  end
`endif
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: two byte-sources modelled as FIFOs, MAC ack patterns.
module tb_eth_tx_arbiter;
  localparam int NS  = 2;
  localparam int GAP = 12;
  localparam int TMO = 16;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] grant;
  logic          busy;
  logic          tout;

  eth_tx_arbiter_if #(.NUM_SRC(NS)) bus();

`ifdef ETH_TX_ARB_STATS_EN
  logic [NS*16-1:0] frame_cnt;
  logic [NS*8-1:0]  abort_cnt;
`endif

  eth_tx_arbiter #(
    .NUM_SRC        (NS),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_tx_i  (clk),
    .rst_n     (rst_n),
    .bus_if    (bus),
    .grant_o   (grant),
    .busy_o    (busy),
    .timeout_o (tout)
`ifdef ETH_TX_ARB_STATS_EN
    ,
    .frame_cnt_o (frame_cnt),
    .abort_cnt_o (abort_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_mode = 0;

  logic       src_en   [NS];
  int         src_pos  [NS];
  int         src_len  [NS];
  logic [7:0] src_base [NS];

  logic          h_valid [$];
  logic [7:0]    h_data  [$];
  logic          h_ack   [$];
  logic [NS-1:0] h_grant [$];
  logic          h_busy  [$];
  logic          h_tout  [$];
  logic [NS-1:0] h_sack  [$];
  logic [7:0]    log_data [$];
  int            log_src  [$];
  int            log_cyc  [$];

  task automatic src_clear();
    for (int k = 0; k < NS; k++) begin
      src_en[k] = 1'b0; src_pos[k] = 0; src_len[k] = 0; src_base[k] = 8'h00;
    end
  endtask

  task automatic hist_clear();
    h_valid.delete(); h_data.delete(); h_ack.delete(); h_grant.delete();
    h_busy.delete(); h_tout.delete(); h_sack.delete();
    log_data.delete(); log_src.delete(); log_cyc.delete();
    cyc = 0;
  endtask

  // One iteration per clock: drive sources from the FIFO model, sample on negedge, pop on ack.
  task automatic run(input int n);
    logic ack;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NS; k++) begin
        bus.src_valid[k]       = src_en[k] && (src_pos[k] < src_len[k]);
        bus.src_data[8*k +: 8] = src_base[k] + 8'(src_pos[k]);
      end
      case (ack_mode)
        1:       ack = (cyc % 2 == 0);
        2:       ack = 1'b0;
        default: ack = 1'b1;
      endcase
      bus.mac_tx_ack = ack;
      @(negedge clk);
      h_valid.push_back(bus.mac_tx_valid);
      h_data.push_back(bus.mac_tx_data);
      h_ack.push_back(ack);
      h_grant.push_back(grant);
      h_busy.push_back(busy);
      h_tout.push_back(tout);
      h_sack.push_back(bus.src_ack);
      if (bus.mac_tx_valid && ack) begin
        log_data.push_back(bus.mac_tx_data);
        log_src.push_back(grant[1] ? 1 : 0);
        log_cyc.push_back(cyc);
      end
      for (int k = 0; k < NS; k++) begin
        if (bus.src_ack[k]) src_pos[k]++;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_clear();
    ack_mode       = 0;
    bus.src_valid  = '0;
    bus.src_data   = '0;
    bus.mac_tx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hist_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    bus.src_valid  = 2'b11;
    bus.src_data   = 16'h1234;
    bus.mac_tx_ack = 1'b1;
    #2;
    checks++; if (bus.mac_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_mac_valid: got %b expected 0", bus.mac_tx_valid); end
    checks++; if (bus.src_ack !== 2'b00) begin failures++; $display("FAIL reset_src_ack: got %b expected 00", bus.src_ack); end
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (tout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", tout); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, grant, bus.mac_tx_valid} !== 4'b0000) begin failures++; $display("FAIL reset_held: got %b expected 0000", {busy, grant, bus.mac_tx_valid}); end
  endtask

  task automatic test_single();
    int first_v, a0, a1, gaps;
    do_reset();
    src_en[0] = 1'b1; src_len[0] = 60; src_base[0] = 8'h10;
    run(80);
    first_v = -1; a0 = 0; a1 = 0; gaps = 0;
    for (int c = 0; c < h_valid.size(); c++) begin
      if (h_valid[c] && first_v < 0) first_v = c;
      if (h_sack[c][0]) a0++;
      if (h_sack[c][1]) a1++;
      if (h_busy[c] && h_grant[c] == 2'b00) gaps++;
    end
    checks++; if (first_v !== 1) begin failures++; $display("FAIL single_latency: got %0d expected 1", first_v); end
    checks++; if (log_data.size() !== 60) begin failures++; $display("FAIL single_count: got %0d expected 60", log_data.size()); end
    for (int i = 0; i < log_data.size() && i < 60; i++) begin
      checks++;
      if (log_data[i] !== 8'h10 + 8'(i) || log_src[i] !== 0) begin
        failures++; $display("FAIL single_byte[%0d]: got src%0d %h expected src0 %h", i, log_src[i], log_data[i], 8'h10 + 8'(i));
      end
    end
    checks++; if (a0 !== 60) begin failures++; $display("FAIL single_ack0: got %0d expected 60", a0); end
    checks++; if (a1 !== 0) begin failures++; $display("FAIL single_ack1: got %0d expected 0", a1); end
    checks++; if (gaps !== GAP) begin failures++; $display("FAIL single_gap: got %0d expected %0d", gaps, GAP); end
    checks++; if (h_busy[79] !== 1'b0) begin failures++; $display("FAIL single_idle_after: got %b expected 0", h_busy[79]); end
  endtask

  task automatic test_contention();
    int         exp_s [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    logic [7:0] exp_d [14] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h80, 8'h81, 8'h82, 8'h83,
                               8'hC0, 8'hC1, 8'hC2, 8'hE0, 8'hE1};
    do_reset();
    src_en[0] = 1'b1; src_len[0] = 5; src_base[0] = 8'h40;
    src_en[1] = 1'b1; src_len[1] = 4; src_base[1] = 8'h80;
    run(30);
    // Re-arm both during src1's gap: rotation must hand the next frame to src0
    src_pos[0] = 0; src_len[0] = 3; src_base[0] = 8'hC0;
    src_pos[1] = 0; src_len[1] = 2; src_base[1] = 8'hE0;
    run(40);
    checks++; if (log_data.size() !== 14) begin failures++; $display("FAIL contention_count: got %0d expected 14", log_data.size()); end
    for (int i = 0; i < log_data.size() && i < 14; i++) begin
      checks++;
      if (log_src[i] !== exp_s[i] || log_data[i] !== exp_d[i]) begin
        failures++; $display("FAIL contention_byte[%0d]: got src%0d %h expected src%0d %h", i, log_src[i], log_data[i], exp_s[i], exp_d[i]);
      end
    end
    if (log_cyc.size() >= 14) begin
      checks++; if (log_cyc[5] !== 20) begin failures++; $display("FAIL contention_src1_start: got %0d expected 20", log_cyc[5]); end
      checks++; if (log_cyc[9] !== 38) begin failures++; $display("FAIL contention_round3_start: got %0d expected 38", log_cyc[9]); end
    end
  endtask

  task automatic test_late_request();
    int drop, s1;
    do_reset();
    src_en[0] = 1'b1; src_len[0] = 8; src_base[0] = 8'h20;
    run(4);
    src_en[1] = 1'b1; src_len[1] = 3; src_base[1] = 8'h60;
    run(40);
    drop = -1; s1 = -1;
    for (int c = 0; c < h_valid.size(); c++) begin
      if (drop < 0 && h_grant[c] != 2'b00 && !h_valid[c]) drop = c;
    end
    for (int i = 0; i < log_src.size(); i++) begin
      if (s1 < 0 && log_src[i] == 1) s1 = log_cyc[i];
    end
    checks++; if (drop !== 9) begin failures++; $display("FAIL late_drop_cycle: got %0d expected 9", drop); end
    // Arbitration happens GAP+1 cycles after the drop; the first byte follows one cycle later
    checks++; if (s1 - drop !== GAP + 2) begin failures++; $display("FAIL late_src1_start: got %0d expected %0d", s1 - drop, GAP + 2); end
    checks++; if (log_data.size() !== 11) begin failures++; $display("FAIL late_count: got %0d expected 11", log_data.size()); end
    for (int i = 0; i < log_data.size() && i < 11; i++) begin
      checks++;
      if (i < 8 ? (log_src[i] !== 0 || log_data[i] !== 8'h20 + 8'(i))
                : (log_src[i] !== 1 || log_data[i] !== 8'h60 + 8'(i - 8))) begin
        failures++; $display("FAIL late_byte[%0d]: got src%0d %h", i, log_src[i], log_data[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int holds, acks;
    do_reset();
    ack_mode = 1;
    src_en[0] = 1'b1; src_len[0] = 6; src_base[0] = 8'hA0;
    run(24);
    holds = 0; acks = 0;
    for (int c = 0; c + 1 < h_valid.size(); c++) begin
      if (h_valid[c] && !h_ack[c] && (!h_valid[c+1] || h_data[c+1] !== h_data[c])) holds++;
    end
    for (int c = 0; c < h_sack.size(); c++) begin
      if (h_sack[c][0]) acks++;
    end
    checks++; if (holds !== 0) begin failures++; $display("FAIL bp_hold: got %0d unstable bytes expected 0", holds); end
    checks++; if (acks !== 6) begin failures++; $display("FAIL bp_acks: got %0d expected 6", acks); end
    checks++; if (log_data.size() !== 6) begin failures++; $display("FAIL bp_count: got %0d expected 6", log_data.size()); end
    for (int i = 0; i < log_data.size() && i < 6; i++) begin
      checks++;
      if (log_data[i] !== 8'hA0 + 8'(i)) begin
        failures++; $display("FAIL bp_byte[%0d]: got %h expected %h", i, log_data[i], 8'hA0 + 8'(i));
      end
    end
  endtask

  task automatic test_watchdog();
    int pulses, first_t, stall_acks, g0;
    do_reset();
    ack_mode = 2;
    src_en[0] = 1'b1; src_len[0] = 10; src_base[0] = 8'h30;
    src_en[1] = 1'b1; src_len[1] = 3;  src_base[1] = 8'h70;
    run(20);
    ack_mode = 0;
    run(40);
    pulses = 0; first_t = -1; stall_acks = 0; g0 = 0;
    for (int c = 0; c < h_tout.size(); c++) begin
      if (h_tout[c]) begin pulses++; if (first_t < 0) first_t = c; end
      if (c < 20 && h_sack[c] != 2'b00) stall_acks++;
      if (c >= 17 && h_grant[c][0]) g0++;
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL wd_pulses: got %0d expected 1", pulses); end
    // 16 stalled BUSY cycles (1..16), pulse visible on the first GAP cycle
    checks++; if (first_t !== 17) begin failures++; $display("FAIL wd_pulse_cycle: got %0d expected 17", first_t); end
    checks++; if (stall_acks !== 0) begin failures++; $display("FAIL wd_stall_acks: got %0d expected 0", stall_acks); end
    checks++; if (g0 !== 0) begin failures++; $display("FAIL wd_masked_regrant: got %0d src0 grant cycles expected 0", g0); end
    checks++; if (log_data.size() !== 3) begin failures++; $display("FAIL wd_src1_count: got %0d expected 3", log_data.size()); end
    for (int i = 0; i < log_data.size() && i < 3; i++) begin
      checks++;
      if (log_src[i] !== 1 || log_data[i] !== 8'h70 + 8'(i)) begin
        failures++; $display("FAIL wd_src1_byte[%0d]: got src%0d %h expected src1 %h", i, log_src[i], log_data[i], 8'h70 + 8'(i));
      end
    end
    src_en[0] = 1'b0;
    run(2);
    src_en[0] = 1'b1; src_pos[0] = 0; src_len[0] = 2; src_base[0] = 8'h50;
    run(8);
    checks++; if (log_data.size() !== 5) begin failures++; $display("FAIL wd_unmask_count: got %0d expected 5", log_data.size()); end
    if (log_data.size() >= 5) begin
      checks++;
      if (log_src[3] !== 0 || log_data[3] !== 8'h50 || log_src[4] !== 0 || log_data[4] !== 8'h51) begin
        failures++; $display("FAIL wd_unmask_bytes: got src%0d %h src%0d %h expected src0 50 src0 51", log_src[3], log_data[3], log_src[4], log_data[4]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    src_en[0] = 1'b1; src_len[0] = 30; src_base[0] = 8'h00;
    run(10);
    checks++; if (bus.mac_tx_valid !== 1'b1) begin failures++; $display("FAIL rstmid_in_frame: got %b expected 1", bus.mac_tx_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mac_tx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_mac_valid: got %b expected 0", bus.mac_tx_valid); end
    checks++; if (bus.src_ack !== 2'b00) begin failures++; $display("FAIL rstmid_src_ack: got %b expected 00", bus.src_ack); end
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_grant_busy: got %b/%b expected 00/0", grant, busy); end
    src_clear();
    src_en[1] = 1'b1; src_len[1] = 4; src_base[1] = 8'h90;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hist_clear();
    run(10);
    checks++; if (log_data.size() !== 4) begin failures++; $display("FAIL rstmid_count: got %0d expected 4", log_data.size()); end
    if (log_data.size() >= 1) begin
      checks++;
      if (log_src[0] !== 1 || log_data[0] !== 8'h90 || log_cyc[0] !== 1) begin
        failures++; $display("FAIL rstmid_first: got src%0d %h at %0d expected src1 90 at 1", log_src[0], log_data[0], log_cyc[0]);
      end
    end
    checks++; if (h_grant[1] !== 2'b10) begin failures++; $display("FAIL rstmid_grant: got %b expected 10", h_grant[1]); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_late_request();
    test_backpressure();
    test_watchdog();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
